// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues imem word requests
// and buffers returned (pc, inst) pairs ahead of the IF/ID register.
module fetch_queue #(
  parameter int          IMEM_ADDR_WIDTH = 10,
  parameter int          FQ_DEPTH        = 4,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       imem_req,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  output logic                       fq_valid,
  output logic [31:0]                fq_pc,
  output logic [31:0]                fq_inst,
  input  logic                       fq_ready
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pc_mem_q [FQ_DEPTH];
  logic [31:0]     inst_mem_q [FQ_DEPTH];

  logic [31:0]     rpc;
  logic            enq;
  logic            deq;
  logic [CW-1:0]   cnt_nxt;
  logic            has_room;
  logic            unused_ok;

  assign unused_ok = ^redirect_pc[1:0];
  assign rpc       = {redirect_pc[31:2], 2'b00};
  assign deq       = (count_q != '0) && fq_ready;
  assign enq       = (state_q == REQ) && imem_ack && !redirect;
  assign cnt_nxt   = count_q + CW'(enq) - CW'(deq);
  assign has_room  = cnt_nxt < CW'(FQ_DEPTH);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = cnt_nxt;
    if (redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = rpc;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(deq);
      wr_ptr_d = wr_ptr_q + PW'(enq);
      if (enq) fetch_pc_d = fetch_pc_q + 32'd4;
    end
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          state_d  = REQ;
          req_pc_d = rpc;
        end else if (has_room) begin
          state_d  = REQ;
          req_pc_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            req_pc_d = rpc;
          end else if (has_room) begin
            req_pc_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect) begin
          // request stays up at the stale address; its data is dropped
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_d  = REQ;
          req_pc_d = redirect ? rpc : fetch_pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (enq) begin
        pc_mem_q[wr_ptr_q]   <= req_pc_q;
        inst_mem_q[wr_ptr_q] <= imem_rdata;
      end
    end
  end

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = req_pc_q[IMEM_ADDR_WIDTH+1:2];
  assign fq_valid  = (count_q != '0);
  assign fq_pc     = pc_mem_q[rd_ptr_q];
  assign fq_inst   = inst_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_queue.sv
// Random + directed bench for fetch_queue against a queue-based
// reference model of the fetch/flush rules.
module tb_fetch_queue;

  localparam int AW = 10;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          fq_valid;
  logic [31:0]   fq_pc;
  logic [31:0]   fq_inst;
  logic          fq_ready;

  fetch_queue #(
    .IMEM_ADDR_WIDTH(AW),
    .FQ_DEPTH(D),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .fq_valid(fq_valid),
    .fq_pc(fq_pc),
    .fq_inst(fq_inst),
    .fq_ready(fq_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // reference model
  bit          m_busy;
  bit          m_stale;
  logic [31:0] m_fetch;
  logic [31:0] m_req_pc;
  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];

  // stimulus knobs
  int ack_lat;
  int rdy_pct;
  int redir_pct;
  int lat_cnt;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(logic [AW-1:0] w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic model_reset();
    m_busy   = 0;
    m_stale  = 0;
    m_fetch  = 32'h0;
    m_req_pc = 32'h0;
    mq_pc.delete();
    mq_inst.delete();
    lat_cnt  = 0;
  endtask

  task automatic model_edge();
    bit ack;
    ack = m_busy && imem_ack;
    if (redirect) begin
      mq_pc.delete();
      mq_inst.delete();
      m_fetch = {redirect_pc[31:2], 2'b00};
      if (!m_busy || ack) begin
        m_busy   = 1;
        m_stale  = 0;
        m_req_pc = m_fetch;
      end else begin
        m_stale = 1;
      end
    end else begin
      if (mq_pc.size() > 0 && fq_ready) begin
        void'(mq_pc.pop_front());
        void'(mq_inst.pop_front());
      end
      if (ack) begin
        if (!m_stale) begin
          mq_pc.push_back(m_req_pc);
          mq_inst.push_back(inst_of(m_req_pc[AW+1:2]));
          m_fetch = m_fetch + 32'd4;
        end
        m_stale = 0;
        m_busy  = (mq_pc.size() < D);
        if (m_busy) m_req_pc = m_fetch;
      end else if (!m_busy && mq_pc.size() < D) begin
        m_busy   = 1;
        m_req_pc = m_fetch;
      end
    end
    if (imem_req && !imem_ack) lat_cnt++;
    else lat_cnt = 0;
  endtask

  task automatic compare();
    check("imem_req", 32'(imem_req), 32'(m_busy));
    if (m_busy) check("imem_addr", 32'(imem_addr), 32'(m_req_pc[AW+1:2]));
    check("fq_valid", 32'(fq_valid), 32'(mq_pc.size() > 0));
    if (mq_pc.size() > 0) begin
      check("fq_pc", fq_pc, mq_pc[0]);
      check("fq_inst", fq_inst, mq_inst[0]);
    end
  endtask

  task automatic drive();
    bit a;
    fq_ready = ($urandom_range(99) < rdy_pct);
    if (ack_lat < 0) a = imem_req && ($urandom_range(1) == 1);
    else a = imem_req && (lat_cnt >= ack_lat);
    imem_ack    = a;
    imem_rdata  = a ? inst_of(imem_addr) : $urandom;
    redirect    = ($urandom_range(99) < redir_pct);
    redirect_pc = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    drive();
  endtask

  task automatic check_reset_vals();
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_valid", 32'(fq_valid), 32'h0);
    check("rst_pc", fq_pc, 32'h0);
    check("rst_inst", fq_inst, 32'h0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_b = 1'b1;
    drive();
  endtask

  task automatic wait_req_lat(int want);
    bit hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step();
      if (imem_req && lat_cnt == want && !redirect) hit = 1;
    end
    check("wait_timeout", 32'(hit), 32'h1);
  endtask

  initial begin
    reset_b     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    fq_ready    = 1'b0;
    ack_lat     = 0;
    rdy_pct     = 100;
    redir_pct   = 0;
    model_reset();
    #1;
    check_reset_vals();
    release_reset();

    // steady stream
    repeat (20) step();

    // back-pressure: fill then drain
    rdy_pct = 0;
    repeat (10) step();
    check("full_req", 32'(imem_req), 32'h0);
    check("full_head", fq_pc, mq_pc[0]);
    rdy_pct = 100;
    repeat (10) step();

    // redirect to unaligned pc in a steady stream
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    step();
    check("redir_valid", 32'(fq_valid), 32'h0);
    check("redir_addr", 32'(imem_addr), 32'h10);
    repeat (6) step();

    // redirect while a slow request is outstanding
    ack_lat = 3;
    wait_req_lat(1);
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    repeat (12) step();

    // back-to-back redirects during DROP
    wait_req_lat(0);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    repeat (15) step();

    // pc wrap-around
    ack_lat     = 0;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    repeat (8) step();

    // random phases
    for (int p = 0; p < 8; p++) begin
      ack_lat   = $urandom_range(4) - 1;
      rdy_pct   = $urandom_range(100);
      redir_pct = $urandom_range(8);
      repeat (300) step();
    end

    // asynchronous reset mid-stream
    ack_lat   = 2;
    rdy_pct   = 0;
    redir_pct = 0;
    repeat (12) step();
    #2;
    reset_b = 1'b0;
    #1;
    check_reset_vals();
    redirect = 1'b0;
    imem_ack = 1'b0;
    release_reset();
    ack_lat = 0;
    rdy_pct = 100;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue sitting between the instruction memory and the IF/ID pipeline register of the 5-stage RISC-V core. It owns the fetch PC and issues word requests to a variable-latency imem over a req/ack handshake. Returned instructions are buffered, with their PCs, in a small FIFO that drains into IF/ID under the pipeline stall signal. Branch redirects flush the queue and discard any in-flight response.

## Interface
- IMEM_ADDR_WIDTH, 10, imem word-address width
- FQ_DEPTH, 4, queue entries (power of 2, ≥2)
- RESET_PC, 32'h0, fetch PC after reset
- clk  in  1  system clock
- reset_b  in  1  reset; one clock, asynchronous, active-low
- redirect  in  1  branch taken in EX: flush queue, restart at redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0)
- imem_req  out  1  request valid
- imem_addr  out  IMEM_ADDR_WIDTH  word address, = req_pc[IMEM_ADDR_WIDTH+1:2]
- imem_ack  in  1  request completes this cycle; imem_rdata valid
- imem_rdata  in  32  instruction word
- fq_valid  out  1  queue head valid
- fq_pc  out  32  PC of head instruction
- fq_inst  out  32  head instruction
- fq_ready  in  1  IF/ID accepts head (= ~if_stall)

## Operation
- Registers: fetch_pc (next PC to request), req_pc (PC of outstanding request), FIFO (pc, inst) with rd/wr pointers and count (0..FQ_DEPTH), 2-bit state.
- States:
  - IDLE: imem_req=0. Goes to REQ when count_next < FQ_DEPTH; req_pc<=fetch_pc.
  - REQ: imem_req=1, address from req_pc. On imem_ack, enqueue {req_pc, imem_rdata}, fetch_pc<=fetch_pc+4. Next: REQ with req_pc<=fetch_pc+4 if count_next < FQ_DEPTH, else IDLE.
  - DROP: imem_req=1, address held at stale req_pc. On imem_ack, data discarded; go to REQ with req_pc<=fetch_pc.
- imem_req/imem_addr never change while a request is un-acked. Once raised, req stays high until ack, including across redirects.
- Dequeue when fq_valid && fq_ready. Enqueue and dequeue may occur in the same cycle. count_next accounts for both.
- fq_valid = (count != 0). fq_pc and fq_inst come from the FIFO head register array, with no bypass of imem_rdata.
- Redirect has priority over everything else in its cycle:
  - count<=0, pointers reset, fetch_pc<=redirect_pc.
  - Any same-cycle enqueue is suppressed. A same-cycle dequeue has no further effect.
  - REQ with ack → REQ, req_pc<=redirect_pc (ack data discarded).
  - REQ without ack → DROP.
  - DROP → stays DROP; on ack, go to REQ at the new fetch_pc.
  - IDLE → REQ at redirect_pc.
  - Back-to-back redirects: last one wins.
- fetch_pc wraps modulo 2^32. No alignment or range check beyond the forced [1:0]=0.

## Timing
- Reset (async, immediate): state=IDLE, fetch_pc=req_pc=RESET_PC, count=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC[IMEM_ADDR_WIDTH+1:2], fq_valid=0, fq_pc=0, fq_inst=0.
- First edge after reset release: IDLE→REQ, so imem_req rises 1 cycle after release.
- Latency from ack to fq_valid: 1 cycle (registered enqueue).
- With imem_ack tied 1 and fq_ready=1: sustained throughput 1 instruction/cycle, count steady at 1.
- First fq_valid: 2 cycles after reset release.
- Redirect in cycle t:
  - fq_valid=0 in cycle t+1.
  - With ack tied 1, imem_addr=redirect_pc>>2 in t+1 and first valid new instruction in t+2.
- Full queue (count=FQ_DEPTH): no new request issued. Outstanding requests never exceed free entries, so no overflow.

## Test plan
- Reset release, imem_ack=1, fq_ready=1 → imem_addr 0,1,2,3…; fq_pc 0x0,0x4,0x8… on consecutive cycles; fq_inst matches imem contents.
- fq_ready=0 for 10 cycles →
  - queue fills to 4 entries (pc 0x0–0xC), imem_req drops to 0, fq_pc holds 0x0.
  - Raising fq_ready yields 0x0,0x4,0x8,0xC,0x10… with no loss or duplication.
- Steady stream, redirect=1 with redirect_pc=0x43 while count=2 → next cycle fq_valid=0, imem_addr=0x10; two cycles later fq_pc=0x40.
- imem_ack after 3-cycle latency, redirect to 0x80 one cycle after request for 0x8 →
  - imem_addr stays 0x2 until ack.
  - Returned word is never presented.
  - Next request imem_addr=0x20; first output fq_pc=0x80.
- Redirects in consecutive cycles to 0x100 then 0x200 during DROP → only 0x200 stream appears.
- Assert reset_b mid-stream with queue full and request pending → outputs go to reset values without waiting for clk. After release, fetch restarts at RESET_PC.
